// File: rtl/clock_pkg.sv
// Shared clock definitions: mode encoding used by the
// time-set controller and the timer, plus blink field lookup.
package clock_pkg;

  localparam logic [1:0] MODE_RUN        = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR   = 2'd1;
  localparam logic [1:0] MODE_SET_MINUTE = 2'd2;
  localparam logic [1:0] MODE_SET_SECOND = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = MODE_RUN,
    ST_HOUR   = MODE_SET_HOUR,
    ST_MINUTE = MODE_SET_MINUTE,
    ST_SECOND = MODE_SET_SECOND
  } mode_e;

  // Blank-mask bit for the field being edited:
  // bit2 = hour, bit1 = minute, bit0 = second.
  function automatic logic [2:0] field_mask(
    input logic [1:0] m
  );
    logic [2:0] r;
    r = 3'b000;
    case (m)
      MODE_SET_HOUR:   r = 3'b100;
      MODE_SET_MINUTE: r = 3'b010;
      MODE_SET_SECOND: r = 3'b001;
      default:         r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_set_controller_button_repeat.sv
// button_repeat: edge detect + hold-to-repeat for one button.
// Ports: clk, rst (sync, active-high), level (debounced button),
//   gate (pulse enable), hold_clr (zero hold counter),
//   tick (5 Hz enable), pulse (1-cycle registered strobe).
module button_repeat #(
  parameter int HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic gate,
  input  logic hold_clr,
  input  logic tick,
  output logic pulse
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

  logic          prev;
  logic [CW-1:0] cnt;
  logic          edge_hit;
  logic          rpt_hit;

  assign edge_hit = level & ~prev;
  // Repeat fires on ticks after the counter has saturated.
  assign rpt_hit  = level & tick & (cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      // prev always tracks, so an edge masked by gate is lost.
      prev  <= level;
      pulse <= gate & (edge_hit | rpt_hit);
      if (!level || hold_clr) begin
        cnt <= '0;
      end else if (tick && cnt != HOLD_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-adjust sequencer: mode FSM, inc/dec strobes with
// auto-repeat, blink masks and idle return to RUN.
// Ports: clk, rst (sync, active-high), mode_tick, inc_level,
//   dec_level, enable_1hz, enable_5hz -> mode, run_enable,
//   inc_pulse, dec_pulse, blank_mask[2:0] (hour,min,sec).
module time_set_controller
  import clock_pkg::*;
#(
  parameter int HOLD_TICKS   = 3,
  parameter int IDLE_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_tick,
  input  logic       inc_level,
  input  logic       dec_level,
  input  logic       enable_1hz,
  input  logic       enable_5hz,
  output logic [1:0] mode,
  output logic       run_enable,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic [2:0] blank_mask
);

  localparam int IW = $clog2(IDLE_SECONDS + 1);
  localparam logic [IW-1:0] IDLE_LAST =
    IW'(IDLE_SECONDS - 1);

  mode_e         state;
  mode_e         state_nx;
  logic [IW-1:0] idle_cnt;
  logic          phase;
  logic          is_set;
  logic          any_btn;
  logic          conflict;
  logic          timeout;
  logic          chg;
  logic          gate;
  logic          hold_clr;

  assign is_set   = (state != ST_RUN);
  assign any_btn  = inc_level | dec_level;
  assign conflict = inc_level & dec_level;

  // Timeout fires on the tick that brings the count to
  // IDLE_SECONDS, so RUN is visible the following cycle.
  assign timeout  = is_set & enable_1hz & ~any_btn &
                    ~mode_tick & (idle_cnt == IDLE_LAST);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      mode_tick: state_nx = mode_e'(state + 2'd1);
      timeout:   state_nx = ST_RUN;
      default:   state_nx = state;
    endcase
  end

  assign chg      = (state_nx != state);
  // A mode change wins over any button event that cycle.
  assign gate     = is_set & ~conflict & ~mode_tick;
  assign hold_clr = ~is_set | conflict | chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      run_enable <= 1'b1;
      idle_cnt   <= '0;
      phase      <= 1'b0;
    end else begin
      state      <= state_nx;
      run_enable <= (state_nx == ST_RUN);
      if (chg || !is_set || any_btn) begin
        idle_cnt <= '0;
      end else if (enable_1hz) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (chg || !is_set) begin
        phase <= 1'b0;
      end else if (enable_5hz) begin
        phase <= ~phase;
      end
    end
  end

  assign mode = state;

  assign blank_mask =
    (is_set && phase && !any_btn) ? field_mask(state)
                                  : 3'b000;

  button_repeat #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_inc (
    .clk      (clk),
    .rst      (rst),
    .level    (inc_level),
    .gate     (gate),
    .hold_clr (hold_clr),
    .tick     (enable_5hz),
    .pulse    (inc_pulse)
  );

  button_repeat #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_dec (
    .clk      (clk),
    .rst      (rst),
    .level    (dec_level),
    .gate     (gate),
    .hold_clr (hold_clr),
    .tick     (enable_5hz),
    .pulse    (dec_pulse)
  );

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: expected strobes
// are queued by stimulus and matched by a negedge monitor.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_tick = 1'b0;
  logic       inc_level = 1'b0;
  logic       dec_level = 1'b0;
  logic       enable_1hz = 1'b0;
  logic       enable_5hz = 1'b0;
  logic [1:0] mode;
  logic       run_enable;
  logic       inc_pulse;
  logic       dec_pulse;
  logic [2:0] blank_mask;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit is_dec;
    int at;
  } exp_t;

  exp_t sb[$];

  time_set_controller #(
    .HOLD_TICKS(3),
    .IDLE_SECONDS(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_tick  (mode_tick),
    .inc_level  (inc_level),
    .dec_level  (dec_level),
    .enable_1hz (enable_1hz),
    .enable_5hz (enable_5hz),
    .mode       (mode),
    .run_enable (run_enable),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input bit d);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL stray_%s_pulse: got pulse at cycle %0d want none",
               d ? "dec" : "inc", cyc);
    end else begin
      e = sb.pop_front();
      if (e.is_dec != d || e.at != cyc) begin
        n_fail++;
        $display("FAIL pulse_match: got %s at %0d want %s at %0d",
                 d ? "dec" : "inc", cyc,
                 e.is_dec ? "dec" : "inc", e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (inc_pulse === 1'b1) pop_chk(1'b0);
    if (dec_pulse === 1'b1) pop_chk(1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input bit d);
    exp_t e;
    e.is_dec = d;
    e.at = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic mtick();
    mode_tick = 1'b1;
    step();
    mode_tick = 1'b0;
  endtask

  task automatic tick5(input bit want_inc);
    enable_5hz = 1'b1;
    if (want_inc) expect_pulse(1'b0);
    step();
    enable_5hz = 1'b0;
    step();
    step();
  endtask

  task automatic tick1();
    enable_1hz = 1'b1;
    step();
    enable_1hz = 1'b0;
    step();
  endtask

  task automatic drain(input string name);
    step();
    step();
    chk(name, sb.size(), 0);
  endtask

  logic [1:0] want_mode;

  initial begin
    // 1: reset values and mode sequence
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_mode", mode, 0);
    chk("rst_run", run_enable, 1);
    chk("rst_blank", blank_mask, 0);
    chk("rst_pulses", {inc_pulse, dec_pulse}, 0);
    for (int k = 1; k <= 4; k++) begin
      mode_tick = 1'b1;
      step();
      mode_tick = 1'b0;
      want_mode = 2'(k);
      chk("seq_mode", mode, want_mode);
      chk("seq_run", run_enable, (k == 4) ? 1 : 0);
      step();
    end

    // 2: hold inc in SET_MINUTE for 6 ticks
    mtick();
    mtick();
    chk("t2_mode", mode, 2);
    inc_level = 1'b1;
    expect_pulse(1'b0);
    step();
    step();
    for (int i = 1; i <= 6; i++) tick5(i >= 4);
    inc_level = 1'b0;
    drain("t2_pulses_done");

    // 3: conflict in SET_HOUR, then release dec
    mtick();
    mtick();
    mtick();
    chk("t3_mode", mode, 1);
    inc_level = 1'b1;
    dec_level = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) tick5(1'b0);
    dec_level = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) tick5(1'b0);
    chk("t3_no_early_repeat", sb.size(), 0);
    tick5(1'b1);
    inc_level = 1'b0;
    drain("t3_repeat_done");

    // 4: idle timeout in SET_SECOND, restarted by dec
    mtick();
    mtick();
    chk("t4_mode", mode, 3);
    for (int i = 1; i <= 8; i++) tick1();
    dec_level = 1'b1;
    enable_1hz = 1'b1;
    expect_pulse(1'b1);
    step();
    dec_level = 1'b0;
    enable_1hz = 1'b0;
    step();
    for (int i = 1; i <= 9; i++) tick1();
    chk("t4_still_set", mode, 3);
    enable_1hz = 1'b1;
    step();
    enable_1hz = 1'b0;
    chk("t4_timeout_mode", mode, 0);
    chk("t4_timeout_run", run_enable, 1);
    drain("t4_done");

    // 5: RUN ignores buttons; blink in SET_HOUR
    inc_level = 1'b1;
    step();
    tick5(1'b0);
    chk("t5_run_blank", blank_mask, 0);
    inc_level = 1'b0;
    drain("t5_run_nopulse");
    mtick();
    chk("t5_blank0", blank_mask, 3'b000);
    enable_5hz = 1'b1;
    step();
    enable_5hz = 1'b0;
    chk("t5_blank1", blank_mask, 3'b100);
    enable_5hz = 1'b1;
    step();
    enable_5hz = 1'b0;
    chk("t5_blank2", blank_mask, 3'b000);
    enable_5hz = 1'b1;
    step();
    enable_5hz = 1'b0;
    chk("t5_blank3", blank_mask, 3'b100);
    inc_level = 1'b1;
    expect_pulse(1'b0);
    step();
    chk("t5_blank_held", blank_mask, 3'b000);
    inc_level = 1'b0;
    drain("t5_done");

    // 6: mode_tick beats inc edge; reset mid-repeat
    mode_tick = 1'b1;
    inc_level = 1'b1;
    step();
    mode_tick = 1'b0;
    chk("t6_mode", mode, 2);
    step();
    for (int i = 1; i <= 3; i++) tick5(1'b0);
    tick5(1'b1);
    rst = 1'b1;
    enable_5hz = 1'b1;
    step();
    rst = 1'b0;
    enable_5hz = 1'b0;
    chk("t6_rst_mode", mode, 0);
    chk("t6_rst_pulse", inc_pulse, 0);
    tick5(1'b0);
    tick5(1'b0);
    chk("t6_run", run_enable, 1);
    inc_level = 1'b0;
    drain("t6_done");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the clock's time-adjust path.
- Owns the mode state machine (RUN, SET_HOUR, SET_MINUTE, SET_SECOND).
- Turns debounced button inputs into single-cycle increment/decrement strobes for the timer, with hold-to-auto-repeat.
- Drives per-field blink masks for the seven-segment stage and returns to RUN after an inactivity timeout. Sits between the debounce/freq_divider outputs and the timer.

Parameters:
- HOLD_TICKS, 3, number of enable_5hz ticks a button must be held before auto-repeat starts (600 ms at 5 Hz).
- IDLE_SECONDS, 10, number of enable_1hz ticks with no button activity in a SET state before forced return to RUN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- mode_tick  input  1  one-cycle debounced pulse from the mode button
- inc_level  input  1  debounced level of the increment button, 1 = held
- dec_level  input  1  debounced level of the decrement button, 1 = held
- enable_1hz  input  1  one-cycle 1 Hz enable
- enable_5hz  input  1  one-cycle 5 Hz enable
- mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MINUTE, 3 = SET_SECOND
- run_enable  output  1  1 = timer counts on enable_1hz; 0 only in SET states
- inc_pulse  output  1  one-cycle increment strobe to the timer
- dec_pulse  output  1  one-cycle decrement strobe to the timer
- blank_mask  output  3  bit2 = hour, bit1 = minute, bit0 = second; 1 = blank that field's digits

Behaviour:
- Clock and reset:
  - One clock domain, clk. Reset is synchronous and active-high on rst.
  - Reset forces mode = 0, run_enable = 1, inc_pulse = 0, dec_pulse = 0, blank_mask = 0.
  - Reset also clears the hold counters, idle counter and blink phase.
  - Reset asserted mid-repeat or mid-timeout aborts immediately, with no trailing pulse.
- FSM (registered; mode is the state encoding):
  - mode_tick advances RUN -> SET_HOUR -> SET_MINUTE -> SET_SECOND -> RUN, taking effect the cycle after the tick.
  - Idle timeout in any SET state goes to RUN.
- run_enable is 1 in RUN and 0 in every SET state, registered with the state.
- Edge detect:
  - A registered previous value is kept per button.
  - A rising edge on inc_level produces inc_pulse = 1 the next cycle, but only in a SET state. dec_level works the same way for dec_pulse.
  - In RUN, buttons produce no pulses.
- Auto-repeat, per button:
  - A hold counter clears on release.
  - While the button is held, the counter increments on each enable_5hz, saturating at HOLD_TICKS.
  - Once it has reached HOLD_TICKS, each further enable_5hz while held produces one pulse.
  - Maximum rate is one pulse per 5 Hz tick; pulses are never wider than 1 cycle.
- Conflicts:
  - inc_level and dec_level both 1: no pulses and both hold counters held at 0. An edge occurring during a conflict is discarded.
  - mode_tick in the same cycle as an inc/dec event: the mode change wins and the inc/dec pulse is suppressed for that cycle. Hold counters clear on every mode change.
- Idle timeout:
  - The idle counter clears on entry to a SET state, on any mode_tick, and whenever inc_level or dec_level is 1.
  - Otherwise it increments on enable_1hz.
  - When it reaches IDLE_SECONDS, the FSM goes to RUN the next cycle and the counter clears.
  - The idle counter is inactive (held at 0) in RUN.
- Blink:
  - The phase bit toggles on every enable_5hz while in a SET state, giving 2.5 Hz, and resets to 0 on each state change.
  - blank_mask has the bit of the selected field set when phase = 1 and no button is held; otherwise it is 0.
  - blank_mask is always 0 in RUN.
- Widths:
  - Hold counters are clog2(HOLD_TICKS+1) bits. The idle counter is clog2(IDLE_SECONDS+1) bits.
  - The FSM has no arithmetic beyond saturating and wrapping these counters.

Decomposition:
- Shared package clock_pkg:
  - Mode encoding constants MODE_RUN = 2'd0, MODE_SET_HOUR = 2'd1, MODE_SET_MINUTE = 2'd2, MODE_SET_SECOND = 2'd3.
  - These are consumed by the timer and by this block.
- One natural sub-module, button_repeat:
  - Contains the edge detect, hold counter and repeat-pulse logic.
  - Has a gate input driven by the SET-state/conflict condition.
  - Instantiated twice, once for increment and once for decrement.
- FSM, idle counter and blink stay in the top level of this block.

Test Plan:
1. Reset then 4 mode_ticks -> mode goes 0,1,2,3,0, one cycle after each tick; run_enable = 0 only at modes 1-3; after reset all outputs are 0 except run_enable = 1.
2. In SET_MINUTE, hold inc_level for 6 enable_5hz ticks -> one inc_pulse at the edge, then one pulse on each of ticks 4, 5 and 6; 4 pulses total, each 1 cycle wide.
3. In SET_HOUR, assert inc_level and dec_level together for 10 enable_5hz ticks -> zero inc_pulse/dec_pulse; release dec_level -> auto-repeat restarts only after HOLD_TICKS more ticks.
4. In SET_SECOND, no buttons for 10 enable_1hz ticks -> mode = 0 and run_enable = 1 the cycle after the 10th tick; a dec press at tick 9 restarts the count.
5. In RUN, press inc_level -> no pulses and blank_mask = 0; in SET_HOUR with no buttons -> blank_mask toggles between 3'b100 and 3'b000 on each enable_5hz.
6. mode_tick in the same cycle as an inc_level rising edge, while in SET_HOUR -> mode = 2 and no inc_pulse; assert rst during auto-repeat -> no pulse after the reset cycle and mode = 0.
